// File: rtl/masurare_viteza_pkg.sv
// Shared constants for the wheel-speed measurement block: BCD digit width,
// saturation digits and the default gate length.
package masurare_viteza_pkg;

    localparam int BCD_W               = 4;
    localparam int GATE_CYCLES_DEFAULT = 12500000;

    localparam logic [BCD_W-1:0] SAT_ZECI    = 4'd9;
    localparam logic [BCD_W-1:0] SAT_UNITATI = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO    = 4'd0;
    localparam logic [BCD_W-1:0] BCD_ONE     = 4'd1;
    localparam logic [BCD_W-1:0] BCD_NINE    = 4'd9;

    function automatic logic bcd_is_max(input logic [BCD_W-1:0] zeci,
                                        input logic [BCD_W-1:0] unitati);
        return (zeci == SAT_ZECI) && (unitati == SAT_UNITATI);
    endfunction

endpackage

// File: rtl/masurare_viteza_contor_bcd_saturat.sv
// Two-digit BCD counter that sticks at 99 and flags any further increments.
module contor_bcd_saturat
    import masurare_viteza_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_one,
    input  logic             incr,
    output logic [BCD_W-1:0] zeci,
    output logic [BCD_W-1:0] unitati,
    output logic             overflow
);

    // clear wins over incr; load_one lets an edge on the clearing cycle count as the first of the new window
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zeci     <= BCD_ZERO;
            unitati  <= BCD_ZERO;
            overflow <= 1'b0;
        end else if (clear) begin
            zeci     <= BCD_ZERO;
            unitati  <= load_one ? BCD_ONE : BCD_ZERO;
            overflow <= 1'b0;
        end else if (incr) begin
            if (bcd_is_max(zeci, unitati)) begin
                overflow <= 1'b1;
            end else if (unitati == BCD_NINE) begin
                unitati <= BCD_ZERO;
                zeci    <= zeci + BCD_ONE;
            end else begin
                unitati <= unitati + BCD_ONE;
            end
        end
    end

endmodule

// File: rtl/masurare_viteza.sv
// Counts encoder rising edges over a fixed gate window and presents the
// result as two registered BCD digits with an overflow flag.
module masurare_viteza
    import masurare_viteza_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             puls_encoder,
    input  logic             stop,
    output logic [BCD_W-1:0] cifra_zeci,
    output logic [BCD_W-1:0] cifra_unitati,
    output logic             valid_nou,
    output logic             depasire
);

    localparam int GATE_W = $clog2(GATE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [SYNC_STAGES:0]   prime_r;
    logic                   prev_r;
    logic [GATE_W-1:0]      gate_r;
    logic                   edge_s;
    logic                   terminal_s;
    logic                   clear_s;
    logic                   load_one_s;
    logic [BCD_W-1:0]       acc_zeci;
    logic [BCD_W-1:0]       acc_unitati;
    logic                   acc_overflow;

    // prime_r masks the edge detector until the chain holds real samples, so a high input at reset release is not counted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_r  <= '0;
            prime_r <= '0;
            prev_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], puls_encoder};
            prime_r <= {prime_r[SYNC_STAGES-1:0], 1'b1};
            prev_r  <= sync_r[SYNC_STAGES-1];
        end
    end

    // gate counter, held at zero while stopped so a full window follows stop release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gate_r <= '0;
        end else if (stop || terminal_s) begin
            gate_r <= '0;
        end else begin
            gate_r <= gate_r + GATE_W'(1);
        end
    end

    always_comb begin
        edge_s     = sync_r[SYNC_STAGES-1] & ~prev_r & prime_r[SYNC_STAGES];
        terminal_s = (gate_r == GATE_W'(GATE_CYCLES - 1));
        clear_s    = stop | terminal_s;
        load_one_s = edge_s & terminal_s & ~stop;
    end

    contor_bcd_saturat u_contor (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear_s),
        .load_one (load_one_s),
        .incr     (edge_s),
        .zeci     (acc_zeci),
        .unitati  (acc_unitati),
        .overflow (acc_overflow)
    );

    // result registers: snapshot on the window's last cycle, forced to zero while stopped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cifra_zeci    <= BCD_ZERO;
            cifra_unitati <= BCD_ZERO;
            depasire      <= 1'b0;
            valid_nou     <= 1'b0;
        end else if (stop) begin
            cifra_zeci    <= BCD_ZERO;
            cifra_unitati <= BCD_ZERO;
            depasire      <= 1'b0;
            valid_nou     <= 1'b0;
        end else if (terminal_s) begin
            cifra_zeci    <= acc_zeci;
            cifra_unitati <= acc_unitati;
            depasire      <= acc_overflow;
            valid_nou     <= 1'b1;
        end else begin
            valid_nou     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_masurare_viteza.sv
// Directed bench: a 100-cycle instance for timing cases and a 600-cycle
// instance for the high-count cases, results checked via a scoreboard queue.
module tb_masurare_viteza;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       puls  = 1'b0;
    logic       stop  = 1'b0;
    logic       sel   = 1'b0;

    logic [3:0] d_z, d_u, w_z, w_u;
    logic       d_v, d_d, w_v, w_d;
    logic [8:0] obs_out;
    logic       obs_valid;

    int         total = 0;
    int         bad = 0;
    int         cycle_cnt = 0;
    int         valid_cycle = 0;
    int         t0 = 0;
    int         viol = 0;
    logic [8:0] sb[$];

    masurare_viteza #(.GATE_CYCLES(100), .SYNC_STAGES(2)) u_dut (
        .clock(clock), .reset(reset), .puls_encoder(puls), .stop(stop),
        .cifra_zeci(d_z), .cifra_unitati(d_u), .valid_nou(d_v), .depasire(d_d)
    );

    masurare_viteza #(.GATE_CYCLES(600), .SYNC_STAGES(2)) u_wide (
        .clock(clock), .reset(reset), .puls_encoder(puls), .stop(stop),
        .cifra_zeci(w_z), .cifra_unitati(w_u), .valid_nou(w_v), .depasire(w_d)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    assign obs_out   = sel ? {w_z, w_u, w_d} : {d_z, d_u, d_d};
    assign obs_valid = sel ? w_v : d_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            puls = 1'b1;
            repeat (2) @(negedge clock);
            puls = 1'b0;
            repeat (2) @(negedge clock);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        logic [8:0] e;
        while (obs_valid !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        valid_cycle = cycle_cnt;
        e = (sb.size() > 0) ? sb.pop_front() : 9'h1ff;
        check({tag, "_valid"}, 32'(obs_valid), 32'd1);
        if (obs_valid === 1'b1) begin
            check({tag, "_digits"}, 32'(obs_out), 32'(e));
            @(negedge clock);
            check({tag, "_one_cycle"}, 32'(obs_valid), 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        t0 = cycle_cnt;
    endtask

    initial begin
        // reset state of both instances
        repeat (2) @(negedge clock);
        check("reset_dut", 32'({d_z, d_u, d_d, d_v}), 32'd0);
        check("reset_wide", 32'({w_z, w_u, w_d, w_v}), 32'd0);
        reset = 1'b0;

        // 37 pulses, then 120 (saturation), then 5 on the 600-cycle instance
        sel = 1'b1;
        do_reset();
        repeat (4) @(negedge clock);
        pulses(37);
        sb.push_back({4'd3, 4'd7, 1'b0});
        wait_valid("cnt37", 700);
        pulses(120);
        sb.push_back({4'd9, 4'd9, 1'b1});
        wait_valid("sat120", 700);
        pulses(5);
        sb.push_back({4'd0, 4'd5, 1'b0});
        wait_valid("after_sat", 700);

        // edge landing on the terminal cycle of the 100-cycle instance
        sel = 1'b0;
        do_reset();
        repeat (4) @(negedge clock);
        pulses(9);
        repeat (57) @(negedge clock);
        puls = 1'b1;
        repeat (2) @(negedge clock);
        puls = 1'b0;
        @(negedge clock);
        sb.push_back({4'd0, 4'd9, 1'b0});
        wait_valid("term_edge", 10);
        pulses(4);
        sb.push_back({4'd0, 4'd5, 1'b0});
        wait_valid("term_next", 200);

        // stop at gate count 60 with edges counted
        pulses(14);
        repeat (3) @(negedge clock);
        check("hold_before_stop", 32'(obs_out), 32'({4'd0, 4'd5, 1'b0}));
        stop = 1'b1;
        @(negedge clock);
        check("stop_forced", 32'({obs_out, obs_valid}), 32'd0);
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            if (obs_valid !== 1'b0 || obs_out !== 9'd0) viol++;
        end
        check("stop_quiet", 32'(viol), 32'd0);
        stop = 1'b0;
        t0 = cycle_cnt;
        pulses(6);
        sb.push_back({4'd0, 4'd6, 1'b0});
        wait_valid("after_stop", 150);
        check("stop_latency", 32'(valid_cycle - t0), 32'd100);

        // reset mid-window clears outputs at once
        pulses(15);
        #2 reset = 1'b1;
        #1 check("reset_mid", 32'({d_z, d_u, d_d, d_v}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        t0 = cycle_cnt;
        repeat (4) @(negedge clock);
        pulses(3);
        sb.push_back({4'd0, 4'd3, 1'b0});
        wait_valid("after_reset", 150);
        check("reset_window_len", 32'(valid_cycle - t0), 32'd100);

        // input high across reset release must not count
        @(negedge clock);
        reset = 1'b1;
        puls  = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sb.push_back({4'd0, 4'd0, 1'b0});
        wait_valid("high_at_reset", 150);
        sb.push_back({4'd0, 4'd0, 1'b0});
        wait_valid("high_next", 150);
        puls = 1'b0;
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
